// File: rtl/prog_launcher_if.sv
// Host <-> processor launch bus.
// master: the launcher (drives DutReset/DutStart and the status outputs,
//         samples Go and DutAck).
// slave : the environment (drives Go and DutAck, observes everything else).
interface prog_launcher_if #(
  parameter int unsigned CW = 16
);
  logic          Go;
  logic          DutAck;
  logic          DutReset;
  logic          DutStart;
  logic [3:0]    ProgIdx;
  logic          Busy;
  logic [CW-1:0] CycleCount;
  logic          CountValid;
  logic          TimedOut;
  logic          Done;

  modport master (
    input  Go, DutAck,
    output DutReset, DutStart, ProgIdx, Busy, CycleCount, CountValid,
           TimedOut, Done
  );

  modport slave (
    output Go, DutAck,
    input  DutReset, DutStart, ProgIdx, Busy, CycleCount, CountValid,
           TimedOut, Done
  );
endinterface

// File: rtl/prog_launcher.sv
// Host-side driver for the processor Start/Ack handshake.
// On Go it resets the processor, then launches NUM_PROGS programs back to
// back, timing each one from Start release to Ack and reporting the count.
// Ports:
//   Clk    - clock, posedge only
//   Reset  - synchronous, active-high
//   io_bus - launch bus (master side): Go/DutAck in; DutReset, DutStart,
//            ProgIdx, Busy, CycleCount, CountValid, TimedOut, Done out.
//            All outputs are registered.
module prog_launcher #(
  parameter int unsigned NUM_PROGS    = 3,
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned CW           = 16,
  parameter int unsigned TIMEOUT      = 65535
) (
  input  logic             Clk,
  input  logic             Reset,
  prog_launcher_if.master  io_bus
);

  localparam int unsigned PH_MAX = (RST_CYCLES > START_CYCLES) ? RST_CYCLES : START_CYCLES;
  localparam int unsigned PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PW-1:0] RST_LAST   = PW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] START_LAST = PW'(START_CYCLES - 1);
  localparam logic [CW-1:0] TMO        = CW'(TIMEOUT);
  localparam logic [3:0]    LAST_IDX   = 4'(NUM_PROGS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_START, S_RUN, S_REPORT, S_FINISH
  } state_t;

  state_t        r_state, w_next_state;
  logic [PW-1:0] r_phase, w_phase_nxt;
  logic [CW-1:0] r_run, w_run_nxt;

  logic          r_dut_reset, w_dut_reset_nxt;
  logic          r_dut_start, w_dut_start_nxt;
  logic [3:0]    r_prog_idx, w_prog_idx_nxt;
  logic          r_busy, w_busy_nxt;
  logic [CW-1:0] r_cycle_count, w_cycle_count_nxt;
  logic          r_count_valid, w_count_valid_nxt;
  logic          r_timed_out, w_timed_out_nxt;
  logic          r_done, w_done_nxt;

  // Ack on the first RUN cycle may be the previous program's, so it is blanked.
  logic w_ack_ok, w_timeout, w_entering;
  assign w_ack_ok   = io_bus.DutAck && (r_run >= CW'(2));
  assign w_timeout  = (r_run >= TMO);
  assign w_entering = (w_next_state != r_state);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (io_bus.Go) w_next_state = S_RST;
      S_RST:    if (r_phase == RST_LAST) w_next_state = S_START;
      S_START:  if (r_phase == START_LAST) w_next_state = S_RUN;
      S_RUN: begin
        if (w_ack_ok)       w_next_state = S_REPORT;
        else if (w_timeout) w_next_state = S_FINISH;
      end
      S_REPORT: w_next_state = (r_prog_idx == LAST_IDX) ? S_FINISH : S_START;
      S_FINISH: if (io_bus.Go) w_next_state = S_RST;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output / datapath next values; outputs follow the state being entered
  always_comb begin
    w_dut_reset_nxt   = (w_next_state == S_RST);
    w_dut_start_nxt   = (w_next_state == S_START);
    w_count_valid_nxt = (w_next_state == S_REPORT);
    w_busy_nxt        = (w_next_state != S_IDLE) && (w_next_state != S_FINISH);
    w_prog_idx_nxt    = r_prog_idx;
    w_cycle_count_nxt = r_cycle_count;
    w_timed_out_nxt   = r_timed_out;
    w_done_nxt        = r_done;

    // Phase counter times the fixed-length RST and START pulses
    w_phase_nxt = '0;
    if (!w_entering && (r_state == S_RST || r_state == S_START))
      w_phase_nxt = r_phase + PW'(1);

    // RUN counter: 1 on the first RUN cycle, saturating at TIMEOUT
    w_run_nxt = r_run;
    if (r_state == S_RUN)
      w_run_nxt = w_timeout ? TMO : r_run + CW'(1);
    else if (w_next_state == S_RUN)
      w_run_nxt = CW'(1);
    else if (w_next_state == S_START)
      w_run_nxt = '0;

    if (r_state == S_RUN) begin
      if (w_ack_ok) begin
        w_cycle_count_nxt = r_run;
      end else if (w_timeout) begin
        w_cycle_count_nxt = TMO;
        w_timed_out_nxt   = 1'b1;
      end
    end

    if (w_next_state == S_RST && w_entering) begin
      w_prog_idx_nxt  = '0;
      w_done_nxt      = 1'b0;
      w_timed_out_nxt = 1'b0;
    end

    if (r_state == S_REPORT && w_next_state == S_START)
      w_prog_idx_nxt = r_prog_idx + 4'(1);

    if (w_next_state == S_FINISH)
      w_done_nxt = 1'b1;
  end

  // Counters and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_phase       <= '0;
      r_run         <= '0;
      r_dut_reset   <= 1'b1;
      r_dut_start   <= 1'b0;
      r_prog_idx    <= '0;
      r_busy        <= 1'b0;
      r_cycle_count <= '0;
      r_count_valid <= 1'b0;
      r_timed_out   <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_run         <= w_run_nxt;
      r_dut_reset   <= w_dut_reset_nxt;
      r_dut_start   <= w_dut_start_nxt;
      r_prog_idx    <= w_prog_idx_nxt;
      r_busy        <= w_busy_nxt;
      r_cycle_count <= w_cycle_count_nxt;
      r_count_valid <= w_count_valid_nxt;
      r_timed_out   <= w_timed_out_nxt;
      r_done        <= w_done_nxt;
    end
  end

  assign io_bus.DutReset   = r_dut_reset;
  assign io_bus.DutStart   = r_dut_start;
  assign io_bus.ProgIdx    = r_prog_idx;
  assign io_bus.Busy       = r_busy;
  assign io_bus.CycleCount = r_cycle_count;
  assign io_bus.CountValid = r_count_valid;
  assign io_bus.TimedOut   = r_timed_out;
  assign io_bus.Done       = r_done;

endmodule

// File: doc/prog_launcher.md
Name: prog_launcher

Overview:
- Host-side driver for the processor's Start/Ack handshake; it is the other end of the interface that TopLevel exposes.
- On a Go pulse it resets the processor, then launches NUM_PROGS programs back to back. For each program it pulses Start, waits for Ack, and reports the cycle count.
- Used in the bench harness and in the FPGA wrapper in place of a hand-written stimulus process.

Parameters:
NUM_PROGS, 3, number of programs run per sequence (1..15)
RST_CYCLES, 2, cycles DutReset is held high at sequence start (>=1)
START_CYCLES, 2, cycles DutStart is held high per program (>=1)
CW, 16, width of the cycle counter
TIMEOUT, 65535, RUN cycles without Ack before abort (<= 2**CW-1)

Ports:
Clk  in  1  clock, posedge only
Reset  in  1  synchronous, active-high
Go  in  1  request to start a full sequence; sampled only in IDLE and FINISH
DutAck  in  1  Ack from processor (done flag)
DutReset  out  1  Reset to processor
DutStart  out  1  Start to processor
ProgIdx  out  4  index of the program currently launched or running
Busy  out  1  high from leaving IDLE/FINISH until entering FINISH
CycleCount  out  CW  latched RUN-cycle count of the last completed program
CountValid  out  1  one-cycle strobe when CycleCount updates
TimedOut  out  1  sticky; set on timeout abort
Done  out  1  sticky; sequence finished (normally or by timeout)

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - DutReset=1; DutStart=0.
  - ProgIdx=0; Busy=0; CycleCount=0; CountValid=0; TimedOut=0; Done=0.
  - State=IDLE, internal counters 0.
- Reset asserted mid-sequence aborts immediately to these values; no partial report is made.

States and transitions:
- IDLE: DutReset=0 from the first edge after reset release. Go=1 -> RST.
- RST:
  - DutReset=1 for exactly RST_CYCLES cycles.
  - Entry clears ProgIdx, Done and TimedOut, and sets Busy=1.
  - Then -> START.
- START:
  - DutReset=0; DutStart=1 for exactly START_CYCLES cycles.
  - The RUN counter is cleared on entry.
  - Then -> RUN.
- RUN:
  - DutStart=0; the counter increments every RUN cycle. It reads 1 in the first RUN cycle.
  - Ack blanking: DutAck is ignored on the first RUN cycle, because the previous program's Ack may still be high. The minimum reportable count is therefore 2.
  - DutAck=1 on RUN cycle n>=2 -> REPORT, with CycleCount<=n.
  - If the counter reaches TIMEOUT with no qualifying Ack: CycleCount<=TIMEOUT, TimedOut<=1, -> FINISH. Remaining programs are skipped and CountValid stays 0.
  - If Ack and timeout occur in the same cycle, Ack wins and the program is reported normally.
- REPORT:
  - CountValid=1 for this one cycle.
  - If ProgIdx==NUM_PROGS-1 -> FINISH; otherwise ProgIdx<=ProgIdx+1 -> START.
  - The processor is not re-reset between programs.
- FINISH:
  - Done=1, Busy=0. ProgIdx and CycleCount are held.
  - Go=1 -> RST, which restarts the whole sequence and clears Done and TimedOut.

Other rules:
- Go is ignored while Busy=1.
- Go held high continuously in FINISH restarts every time FINISH is reached. This is intended behaviour.
- DutStart and DutReset are never high in the same cycle.
- The RUN counter saturates at TIMEOUT and never wraps.
- DutAck is ignored outside RUN.

Test Plan:
- Basic run:
  - Stimulus: defaults; Go pulse; model raises Ack on RUN cycles 10, 25 and 7 for programs 0, 1 and 2.
  - Required response: DutReset high 2 cycles, then DutStart high 2 cycles per program. CountValid pulses with CycleCount=10, 25, 7 and ProgIdx=0, 1, 2. Then Done=1, Busy=0, TimedOut=0.
- Stale Ack:
  - Stimulus: model holds Ack=1 through START and the first RUN cycle, drops it, then re-raises it on RUN cycle 5.
  - Required response: no report on RUN cycle 1; CycleCount=5.
- Minimum count:
  - Stimulus: Ack held high throughout RUN.
  - Required response: every program reports CycleCount=2.
- Timeout:
  - Stimulus: TIMEOUT=20; program 1 never acks.
  - Required response: program 0 reports normally. Then TimedOut=1, CycleCount=20, ProgIdx=1, Done=1; no CountValid for program 1.
- Reset and Go handling:
  - Stimulus: Reset asserted during RUN of program 1.
  - Required response: on the next edge DutReset=1, Busy=0, ProgIdx=0, Done=0.
  - Stimulus: Go pulse while Busy.
  - Required response: ignored.
  - Stimulus: Go in FINISH.
  - Required response: clean restart, with Done and TimedOut cleared in the RST entry cycle.
